// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// reset fetch address and the field layout of the IF->ID bus.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } fetch_state_e;

    // Word address of the boot vector (byte 0xBFC00000)
    localparam logic [29:0] RESET_PC_DEF = 30'h2FF0_0000;

    // IF_ID_BUS = {ins[31:0], pc[29:0]}
    localparam int IF_ID_BUS_W = 62;
    localparam int INS_MSB     = 61;
    localparam int INS_LSB     = 30;
    localparam int PC_MSB      = 29;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry output buffer between fetch and decode: an output register that
// drives decode directly, backed by one skid entry that absorbs a word
// arriving while decode is stalled.
module fetch_skid_buf #(
    parameter int W = 62
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o
);

    logic         out_valid_q;
    logic         skid_valid_q;
    logic [W-1:0] out_data_q;
    logic [W-1:0] skid_data_q;
    logic         xfer;

    assign xfer        = out_valid_q & pop_i;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

    // Fill output first, overflow into skid; a transfer refills output from skid
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_data_q   <= '0;
            skid_data_q  <= '0;
        end else if (flush_i) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (xfer) begin
            if (skid_valid_q) begin
                out_data_q   <= skid_data_q;
                skid_valid_q <= push_i;
                if (push_i) begin
                    skid_data_q <= push_data_i;
                end
            end else begin
                out_valid_q <= push_i;
                if (push_i) begin
                    out_data_q <= push_data_i;
                end
            end
        end else if (push_i) begin
            if (!out_valid_q) begin
                out_valid_q <= 1'b1;
                out_data_q  <= push_data_i;
            end else begin
                skid_valid_q <= 1'b1;
                skid_data_q  <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: holds the word PC, keeps at most one request
// outstanding on the req/addr_ok/data_ok SRAM port, and hands fetched words
// to decode through a two-entry buffer. Redirects flush the buffer and mark
// any in-flight fetch stale so its data is dropped on return.
// Optional build macro FETCH_PERF_CNT_EN adds fetch/stall counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [29:0] RESET_PC = RESET_PC_DEF,
    parameter int          BUS_W    = IF_ID_BUS_W
) (
    input  logic             clk,
    input  logic             resetn,
    output logic             inst_req,
    output logic [31:0]      inst_addr,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    input  logic [31:0]      inst_rdata,
    input  logic             redirect_valid,
    input  logic [29:0]      redirect_pc,
    input  logic             id_allowin,
    output logic             if_valid,
    output logic [BUS_W-1:0] IF_ID_BUS
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      perf_fetch_cnt,
    output logic [31:0]      perf_stall_cnt
`endif
);

    fetch_state_e     state_q, state_d;
    logic [29:0]      pc_q, pc_d;
    logic             cancel_q, cancel_d;
    logic             req_q, req_d;
    logic             push;
    logic             transfer;
    logic             addr_acc;
    logic [BUS_W-1:0] push_data;

    assign transfer  = if_valid & id_allowin;
    assign addr_acc  = req_q & inst_addr_ok;
    assign inst_req  = req_q;
    assign inst_addr = {pc_q, 2'b00};

    // Pack the returned word with the PC it was fetched from
    always_comb begin
        push_data                  = '0;
        push_data[INS_MSB:INS_LSB] = inst_rdata;
        push_data[PC_MSB:0]        = pc_q;
    end

    // Next-state logic; a redirect overrides the PC whatever else happens
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cancel_d = cancel_q;
        push     = 1'b0;
        case (state_q)
            S_REQ: begin
                if (addr_acc) begin
                    state_d  = S_WAIT;
                    cancel_d = redirect_valid;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    state_d  = S_REQ;
                    cancel_d = 1'b0;
                    if (!cancel_q && !redirect_valid) begin
                        push = 1'b1;
                        pc_d = pc_q + 30'd1;
                        if (if_valid && !id_allowin) begin
                            state_d = S_FULL;
                        end
                    end
                end else if (redirect_valid) begin
                    cancel_d = 1'b1;
                end
            end
            S_FULL: begin
                if (transfer || redirect_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end
        req_d = (state_d == S_REQ);
    end

    // FSM, PC and registered request; inst_req stays low until the first edge after reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            cancel_q <= 1'b0;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cancel_q <= cancel_d;
            req_q    <= req_d;
        end
    end

    fetch_skid_buf #(
        .W (BUS_W)
    ) u_skid (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (id_allowin),
        .flush_i     (redirect_valid),
        .out_valid_o (if_valid),
        .out_data_o  (IF_ID_BUS)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;

    // Free-running wrap-around counters; redirects do not clear them
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_fetch_q <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if (transfer) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (if_valid && !id_allowin) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: an SRAM responder, a queue-based model of the
// fetch stage, a per-cycle compare process and directed scenarios with
// hand-computed expectations.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [29:0] redirect_pc = 30'd0;
    logic        id_allowin = 1'b1;
    logic        if_valid;
    logic [61:0] IF_ID_BUS;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage dut (
        .clk            (clk),
        .resetn         (resetn),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_allowin     (id_allowin),
        .if_valid       (if_valid),
        .IF_ID_BUS      (IF_ID_BUS)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- SRAM responder ----------------
    bit          s_en = 1'b1;
    int          s_lat = 1;
    bit          s_pend = 1'b0;
    int          s_cnt = 0;
    logic [31:0] s_addr = 32'd0;

    always @(posedge clk) begin
        if (inst_req && inst_addr_ok) begin
            s_pend = 1'b1;
            s_addr = inst_addr;
            s_cnt  = 1;
        end else if (s_pend && inst_data_ok) begin
            s_pend = 1'b0;
        end else if (s_pend) begin
            s_cnt++;
        end
    end

    always @(negedge clk) begin
        inst_addr_ok = s_en && inst_req && !s_pend;
        inst_data_ok = s_pend && (s_cnt >= s_lat);
        inst_rdata   = s_addr ^ 32'h1234_5678;
    end

    // ---------------- behavioural model + compare ----------------
    logic [61:0] mq[$];
    logic [29:0] m_fpc = 30'h2FF0_0000;
    logic [29:0] m_rpc = 30'd0;
    bit          m_outst = 1'b0;
    bit          m_stale = 1'b0;
    bit          m_alive = 1'b0;
    bit          m_req, m_vld;
    logic [31:0] m_pf = 32'd0;
    logic [31:0] m_ps = 32'd0;

    always @(posedge clk) begin
        if (!resetn) begin
            mq.delete();
            m_fpc   = 30'h2FF0_0000;
            m_outst = 1'b0;
            m_stale = 1'b0;
            m_alive = 1'b0;
            m_pf    = 32'd0;
            m_ps    = 32'd0;
        end else begin
            m_req = m_alive && !m_outst && (mq.size() < 2);
            m_vld = (mq.size() > 0);
            if (m_vld && id_allowin)  m_pf = m_pf + 32'd1;
            if (m_vld && !id_allowin) m_ps = m_ps + 32'd1;
            if (redirect_valid) begin
                mq.delete();
                if (m_req && inst_addr_ok) begin
                    m_outst = 1'b1;
                    m_stale = 1'b1;
                end else if (m_outst && inst_data_ok) begin
                    m_outst = 1'b0;
                    m_stale = 1'b0;
                end else if (m_outst) begin
                    m_stale = 1'b1;
                end
                m_fpc = redirect_pc;
            end else begin
                if (m_vld && id_allowin) mq.delete(0);
                if (m_outst && inst_data_ok) begin
                    if (!m_stale) begin
                        mq.push_back({inst_rdata, m_rpc});
                        m_fpc = m_rpc + 30'd1;
                    end
                    m_outst = 1'b0;
                    m_stale = 1'b0;
                end else if (m_req && inst_addr_ok) begin
                    m_outst = 1'b1;
                    m_stale = 1'b0;
                    m_rpc   = m_fpc;
                end
            end
            m_alive = 1'b1;
        end
        #1;
        m_req = m_alive && !m_outst && (mq.size() < 2);
        check("model_inst_req", {63'd0, inst_req}, {63'd0, m_req});
        check("model_if_valid", {63'd0, if_valid}, {63'd0, (mq.size() > 0)});
        if (mq.size() > 0) check("model_bus", {2'b00, IF_ID_BUS}, {2'b00, mq[0]});
        if (m_req) check("model_inst_addr", {32'd0, inst_addr}, {32'd0, m_fpc, 2'b00});
`ifdef FETCH_PERF_CNT_EN
        check("model_perf_fetch", {32'd0, perf_fetch_cnt}, {32'd0, m_pf});
        check("model_perf_stall", {32'd0, perf_stall_cnt}, {32'd0, m_ps});
`endif
    end

    // ---------------- directed scenarios ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("rst_inst_req", {63'd0, inst_req}, 64'd0);
        check("rst_if_valid", {63'd0, if_valid}, 64'd0);
        check("rst_bus", {2'b00, IF_ID_BUS}, 64'd0);
        repeat (4) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Basic fetch, 1-cycle latency, decode always ready
        s_lat = 1; s_en = 1'b1; id_allowin = 1'b1;
        do_reset();
        tick();
        check("first_req", {63'd0, inst_req}, 64'd1);
        check("first_addr", {32'd0, inst_addr}, 64'h0000_0000_BFC0_0000);
        tick(); tick();
        check("first_valid", {63'd0, if_valid}, 64'd1);
        check("first_bus", {2'b00, IF_ID_BUS}, {2'b00, 32'hADF4_5678, 30'h2FF0_0000});
        check("second_addr", {32'd0, inst_addr}, 64'h0000_0000_BFC0_0004);
        tick(); tick();
        check("second_pc", {34'd0, IF_ID_BUS[29:0]}, {34'd0, 30'h2FF0_0001});

        // Decode stall: output + skid fill, request stops, drain in order
        id_allowin = 1'b0;
        do_reset();
        repeat (8) tick();
        check("stall_req", {63'd0, inst_req}, 64'd0);
        check("stall_valid", {63'd0, if_valid}, 64'd1);
        check("stall_pc0", {34'd0, IF_ID_BUS[29:0]}, {34'd0, 30'h2FF0_0000});
        @(negedge clk); id_allowin = 1'b1;
        tick();
        check("drain_pc1", {34'd0, IF_ID_BUS[29:0]}, {34'd0, 30'h2FF0_0001});
        check("drain_req", {63'd0, inst_req}, 64'd1);
        check("drain_addr", {32'd0, inst_addr}, 64'h0000_0000_BFC0_0008);
        repeat (4) tick();

        // Redirect while buffer is full flushes it
        id_allowin = 1'b0;
        do_reset();
        repeat (8) tick();
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 30'h300;
        tick();
        check("full_redir_valid", {63'd0, if_valid}, 64'd0);
        check("full_redir_addr", {32'd0, inst_addr}, 64'h0000_0000_0000_0C00);
        @(negedge clk); redirect_valid = 1'b0; id_allowin = 1'b1;
        repeat (4) tick();

        // Redirect in S_WAIT: returning word dropped
        s_lat = 3;
        do_reset();
        tick(); tick();
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 30'h100;
        tick();
        @(negedge clk); redirect_valid = 1'b0;
        tick(); tick();
        check("wait_redir_valid", {63'd0, if_valid}, 64'd0);
        check("wait_redir_req", {63'd0, inst_req}, 64'd1);
        check("wait_redir_addr", {32'd0, inst_addr}, 64'h0000_0000_0000_0400);

        // Redirect in the same cycle as data_ok
        s_lat = 1;
        do_reset();
        tick(); tick();
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 30'h100;
        tick();
        check("dok_redir_valid", {63'd0, if_valid}, 64'd0);
        check("dok_redir_req", {63'd0, inst_req}, 64'd1);
        check("dok_redir_addr", {32'd0, inst_addr}, 64'h0000_0000_0000_0400);
        @(negedge clk); redirect_valid = 1'b0;
        repeat (3) tick();

        // Redirect in the same cycle as addr_ok: cancelled fetch
        do_reset();
        tick();
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 30'h200;
        tick();
        @(negedge clk); redirect_valid = 1'b0;
        tick();
        check("aok_redir_valid", {63'd0, if_valid}, 64'd0);
        check("aok_redir_req", {63'd0, inst_req}, 64'd1);
        check("aok_redir_addr", {32'd0, inst_addr}, 64'h0000_0000_0000_0800);
        repeat (3) tick();

        // PC wrap at 2^30
        s_en = 1'b0;
        do_reset();
        tick();
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 30'h3FFF_FFFF;
        tick();
        s_en = 1'b1;
        check("wrap_addr_hi", {32'd0, inst_addr}, 64'h0000_0000_FFFF_FFFC);
        @(negedge clk); redirect_valid = 1'b0;
        tick(); tick();
        check("wrap_bus", {2'b00, IF_ID_BUS}, {2'b00, 32'hEDCB_A984, 30'h3FFF_FFFF});
        check("wrap_addr_zero", {32'd0, inst_addr}, 64'd0);
        repeat (3) tick();

        // Reset during S_WAIT with a word held; stray data_ok afterwards
        id_allowin = 1'b0; s_lat = 1;
        do_reset();
        tick(); tick(); tick();
        s_lat = 4;
        tick();
        @(negedge clk); resetn = 1'b0;
        #1;
        check("midrst_valid", {63'd0, if_valid}, 64'd0);
        check("midrst_req", {63'd0, inst_req}, 64'd0);
        check("midrst_bus", {2'b00, IF_ID_BUS}, 64'd0);
        @(negedge clk); resetn = 1'b1;
        tick(); tick(); tick();
        check("midrst_restart_req", {63'd0, inst_req}, 64'd1);
        check("midrst_restart_addr", {32'd0, inst_addr}, 64'h0000_0000_BFC0_0000);
        check("midrst_stray_dropped", {63'd0, if_valid}, 64'd0);
        s_lat = 1;
        tick(); tick();
        check("midrst_fetch_valid", {63'd0, if_valid}, 64'd1);
        check("midrst_fetch_pc", {34'd0, IF_ID_BUS[29:0]}, {34'd0, 30'h2FF0_0000});

        // Mixed traffic: varying stalls, latencies and redirects
        id_allowin = 1'b1;
        do_reset();
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            id_allowin     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = 30'($urandom);
            s_lat          = $urandom_range(1, 3);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        id_allowin = 1'b1;
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
